// File: rtl/txbq_pkg.sv
// NI transaction types (ni_defs) and transaction-buffer entry state (txbq_defs).
package ni_defs;
    typedef enum logic {TX_RD = 1'b0, TX_WR = 1'b1} tx_op_t;

    typedef struct packed {
        tx_op_t      op;
        logic [15:0] addr;
        logic [31:0] data;
    } tx_t;
endpackage

package txbq_defs;
    typedef enum logic [2:0] {
        FREE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } txbq_state_t;

    localparam int TXBQ_MAX_DEPTH = 16;
endpackage

// File: rtl/link.sv
// Valid/ready transaction link carrying one ni_defs::tx_t per handshake.
interface link;
    logic         src_rdy;
    logic         tgt_rdy;
    ni_defs::tx_t tx;

    modport ingress(input src_rdy, input tx, output tgt_rdy);
    modport egress(output src_rdy, output tx, input tgt_rdy);
endinterface

// File: rtl/txbq_entry.sv
// One transaction-buffer slot: stored request plus its lifecycle state.
// Write handling follows TXBQ_WR_POSTED_EN (posted) or waits for an ack.
module txbq_entry
    import ni_defs::*;
    import txbq_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc,
    input  tx_t         alloc_tx,
    input  logic        issue,
    input  logic        rsp,
    input  logic [31:0] rsp_data,
    input  logic        retire,
    output txbq_state_t state,
    output tx_t         tx
);

`ifdef TXBQ_WR_POSTED_EN
    localparam txbq_state_t WR_ISSUED = DONE;
`else
    localparam txbq_state_t WR_ISSUED = WAIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            unique case (state)
                FREE:    if (alloc) state <= ISSUE;
                ISSUE:   if (issue) state <= (tx.op == TX_RD) ? WAIT : WR_ISSUED;
                WAIT:    if (rsp) state <= (tx.op == TX_RD) ? RESP : DONE;
                RESP,
                DONE:    if (retire) state <= FREE;
                default: state <= FREE;
            endcase
        end
    end

    // Payload needs no reset; it is only observed while state is not FREE.
    always_ff @(posedge clk) begin
        if (alloc && state == FREE) begin
            tx <= alloc_tx;
        end else if (rsp && state == WAIT && tx.op == TX_RD) begin
            tx.data <= rsp_data;
        end
    end

endmodule

// File: rtl/txbq.sv
// In-order transaction buffer between core and memory, DEPTH entries.
// Define TXBQ_WR_POSTED_EN to complete writes at issue without a memory ack.
module txbq
    import ni_defs::*;
    import txbq_defs::*;
#(
    parameter int DEPTH    = 4,
    parameter int TXB_ADDR = -1
) (
    input  logic                       clk,
    input  logic                       rst,
    link.ingress                       core_req,
    link.egress                        mem_req,
    link.ingress                       mem_rsp,
    link.egress                        core_rsp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    txbq_state_t      st  [DEPTH];
    tx_t              etx [DEPTH];
    ptr_t             alloc_ptr;
    ptr_t             issue_ptr;
    ptr_t             retire_ptr;
    ptr_t             rsp_ptr;
    logic             rsp_hit;
    logic             do_alloc;
    logic             do_issue;
    logic             do_rsp;
    logic             do_retire;
    logic [DEPTH-1:0] e_alloc;
    logic [DEPTH-1:0] e_issue;
    logic [DEPTH-1:0] e_rsp;
    logic [DEPTH-1:0] e_retire;

    // The buffer's own address is decoded by the NI, not here.
    logic unused_bits;
    assign unused_bits = ^{mem_rsp.tx.op, mem_rsp.tx.addr, TXB_ADDR};

    function automatic ptr_t nxt(input ptr_t p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign core_req.tgt_rdy = !full;
    assign do_alloc         = core_req.src_rdy && !full;

    assign mem_req.src_rdy = (st[issue_ptr] == ISSUE);
    assign mem_req.tx      = etx[issue_ptr];
    assign do_issue        = mem_req.src_rdy && mem_req.tgt_rdy;

    assign core_rsp.src_rdy = (st[retire_ptr] == RESP);
    assign core_rsp.tx      = etx[retire_ptr];
    assign do_retire        = (st[retire_ptr] == DONE)
                            || (core_rsp.src_rdy && core_rsp.tgt_rdy);

    assign mem_rsp.tgt_rdy = 1'b1;
    assign do_rsp          = mem_rsp.src_rdy && rsp_hit;

    // Memory answers in order, so the oldest waiting entry owns the response.
    always_comb begin
        ptr_t k;
        k       = retire_ptr;
        rsp_hit = 1'b0;
        rsp_ptr = retire_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rsp_hit && st[k] == WAIT) begin
                rsp_hit = 1'b1;
                rsp_ptr = k;
            end
            k = nxt(k);
        end
    end

    always_comb begin
        e_alloc             = '0;
        e_issue             = '0;
        e_rsp               = '0;
        e_retire            = '0;
        e_alloc[alloc_ptr]  = do_alloc;
        e_issue[issue_ptr]  = do_issue;
        e_rsp[rsp_ptr]      = do_rsp;
        e_retire[retire_ptr] = do_retire;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        txbq_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .alloc    (e_alloc[g]),
            .alloc_tx (core_req.tx),
            .issue    (e_issue[g]),
            .rsp      (e_rsp[g]),
            .rsp_data (mem_rsp.tx.data),
            .retire   (e_retire[g]),
            .state    (st[g]),
            .tx       (etx[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
        end else begin
            if (do_alloc)  alloc_ptr  <= nxt(alloc_ptr);
            if (do_issue)  issue_ptr  <= nxt(issue_ptr);
            if (do_retire) retire_ptr <= nxt(retire_ptr);
            count <= count + CW'(do_alloc) - CW'(do_retire);
        end
    end

    a_rsp_has_owner: assert property (
        @(posedge clk) disable iff (rst) mem_rsp.src_rdy |-> rsp_hit
    ) else $warning("txbq: mem_rsp dropped, no entry waiting");

`ifdef FORMAL
    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        a_entry_frees: assert property (
            @(posedge clk) disable iff (rst)
            st[g] != FREE |-> s_eventually (st[g] == FREE)
        );
    end
`endif

endmodule
